// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix store, its write-side feeder and the read-side streamer.
// Holds geometry, fill-state encodings, streamer state encoding and the start-legality rule.
package matrix_pkg;

    localparam int ELEM_WIDTH = 8;
    localparam int MAX_DIM    = 5;
    localparam int MAX_ELEM   = MAX_DIM * MAX_DIM;
    localparam int MAX_MATRIX = 2;

    localparam logic [1:0] FILL_EMPTY = 2'b00;
    localparam logic [1:0] FILL_ONE   = 2'b01;
    localparam logic [1:0] FILL_TWO   = 2'b10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Slot 1 exists only once the store holds two matrices; 2'b11 is never a valid fill count.
    function automatic logic requestLegal(
        input logic [7:0] dimX,
        input logic [7:0] dimY,
        input logic       matSel,
        input logic [1:0] fillState
    );
        logic dimsOk;
        logic slotOk;
        dimsOk = (dimX != 8'd0) && (dimX <= 8'(MAX_DIM)) &&
                 (dimY != 8'd0) && (dimY <= 8'(MAX_DIM));
        slotOk = matSel ? (fillState == FILL_TWO)
                        : ((fillState != FILL_EMPTY) && (fillState != 2'b11));
        return dimsOk && slotOk;
    endfunction

endpackage

// File: rtl/matrix_stream_out.sv
// Snapshots one matrix from the packed two-slot read bus and streams it row-major,
// one element per handshake, tagged with row/column and end-of-row/end-of-matrix flags.
module matrix_stream_out
    import matrix_pkg::*;
(
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic                                     matSel,
    input  logic [7:0]                               dimX,
    input  logic [7:0]                               dimY,
    input  logic [MAX_MATRIX*MAX_ELEM*ELEM_WIDTH-1:0] readData,
    input  logic [1:0]                               fillState,
    output logic                                     busy,
    output logic                                     outValid,
    input  logic                                     outReady,
    output logic [ELEM_WIDTH-1:0]                    outElem,
    output logic [2:0]                               outRow,
    output logic [2:0]                               outCol,
    output logic                                     outRowEnd,
    output logic                                     outLast,
    output logic                                     errPulse
);

    localparam int SLOT_W = MAX_ELEM * ELEM_WIDTH;

    logic [0:0]            state;
    logic [2:0]            dimXReg;
    logic [2:0]            dimYReg;
    logic [2:0]            row;
    logic [2:0]            col;
    logic                  errReg;
    logic [ELEM_WIDTH-1:0] snapshot [MAX_ELEM];

    logic [SLOT_W-1:0]     slotData;
    logic                  legal;
    logic                  sending;
    logic                  accept;
    logic                  handshake;
    logic                  atRowEnd;
    logic                  atLast;
    logic [4:0]            elemIdx;

    assign slotData  = matSel ? readData[SLOT_W +: SLOT_W] : readData[0 +: SLOT_W];
    assign legal     = requestLegal(dimX, dimY, matSel, fillState);
    assign sending   = (state == ST_SEND);
    assign accept    = !sending && start && legal;
    assign handshake = sending && outReady;
    assign atRowEnd  = (col == dimXReg - 3'd1);
    assign atLast    = atRowEnd && (row == dimYReg - 3'd1);
    assign elemIdx   = {2'b00, row} * {2'b00, dimXReg} + {2'b00, col};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            dimXReg <= 3'd0;
            dimYReg <= 3'd0;
            row     <= 3'd0;
            col     <= 3'd0;
            errReg  <= 1'b0;
        end else begin
            errReg <= !sending && start && !legal;
            if (!sending) begin
                if (accept) begin
                    dimXReg <= dimX[2:0];
                    dimYReg <= dimY[2:0];
                    row     <= 3'd0;
                    col     <= 3'd0;
                    state   <= ST_SEND;
                end
            end else if (handshake) begin
                if (atLast) begin
                    row   <= 3'd0;
                    col   <= 3'd0;
                    state <= ST_IDLE;
                end else if (atRowEnd) begin
                    col <= 3'd0;
                    row <= row + 3'd1;
                end else begin
                    col <= col + 3'd1;
                end
            end
        end
    end

    // NOTE: the snapshot is data storage with no reset; outputs are gated by state instead.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int e = 0; e < MAX_ELEM; e++) begin
                snapshot[e] <= slotData[e*ELEM_WIDTH +: ELEM_WIDTH];
            end
        end
    end

    assign busy      = sending;
    assign outValid  = sending;
    assign outElem   = sending ? snapshot[elemIdx] : '0;
    assign outRow    = sending ? row : 3'd0;
    assign outCol    = sending ? col : 3'd0;
    assign outRowEnd = sending && atRowEnd;
    assign outLast   = sending && atLast;
    assign errPulse  = errReg;

endmodule

// File: tb/tb_matrix_stream_out.sv
// Self-checking bench for matrix_stream_out: directed scenarios plus randomized streams,
// each compared against a row-major reference sequence built from the matrix contents.
module tb_matrix_stream_out;
    import matrix_pkg::*;

    localparam int BUSW = MAX_MATRIX * MAX_ELEM * ELEM_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  matSel;
    logic [7:0]            dimX;
    logic [7:0]            dimY;
    logic [BUSW-1:0]       readData;
    logic [1:0]            fillState;
    logic                  busy;
    logic                  outValid;
    logic                  outReady;
    logic [ELEM_WIDTH-1:0] outElem;
    logic [2:0]            outRow;
    logic [2:0]            outCol;
    logic                  outRowEnd;
    logic                  outLast;
    logic                  errPulse;

    typedef struct {
        logic [7:0] elem;
        logic [2:0] row;
        logic [2:0] col;
        logic       rowEnd;
        logic       last;
    } expT;

    int checks = 0;
    int errors = 0;
    logic [7:0] mat [MAX_ELEM];

    matrix_stream_out dut (
        .clk(clk), .rst(rst), .start(start), .matSel(matSel),
        .dimX(dimX), .dimY(dimY), .readData(readData), .fillState(fillState),
        .busy(busy), .outValid(outValid), .outReady(outReady),
        .outElem(outElem), .outRow(outRow), .outCol(outCol),
        .outRowEnd(outRowEnd), .outLast(outLast), .errPulse(errPulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scrambleBus();
        for (int i = 0; i < BUSW / 8; i++) readData[i*8 +: 8] = 8'($urandom);
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_busy"},   32'(busy),      0);
        check({tag, "_valid"},  32'(outValid),  0);
        check({tag, "_elem"},   32'(outElem),   0);
        check({tag, "_row"},    32'(outRow),    0);
        check({tag, "_col"},    32'(outCol),    0);
        check({tag, "_rowEnd"}, 32'(outRowEnd), 0);
        check({tag, "_last"},   32'(outLast),   0);
        check({tag, "_err"},    32'(errPulse),  0);
    endtask

    // readyMode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random (mostly ready).
    // abortAfter > 0 returns right after that many handshakes, leaving the stream running.
    task automatic runStream(input int dx, input int dy, input bit sel, input logic [1:0] fill,
                             input int readyMode, input bit holdStart, input int abortAfter);
        expT q[$];
        expT x;
        int  hs  = 0;
        int  cyc = 0;
        bit  rdy;
        scrambleBus();
        for (int e = 0; e < MAX_ELEM; e++) readData[(int'(sel)*MAX_ELEM + e)*8 +: 8] = mat[e];
        dimX = 8'(dx); dimY = 8'(dy); matSel = sel; fillState = fill;
        start = 1'b1; outReady = 1'b0;
        tick();
        if (!holdStart) start = 1'b0;
        for (int r = 0; r < dy; r++) begin
            for (int c = 0; c < dx; c++) begin
                x.elem = mat[r*dx + c]; x.row = 3'(r); x.col = 3'(c);
                x.rowEnd = (c == dx - 1); x.last = (r == dy - 1) && (c == dx - 1);
                q.push_back(x);
            end
        end
        check("accept_busy", 32'(busy), 1);
        // Anything on the inputs from here on must not disturb the snapshot.
        scrambleBus();
        dimX = 8'($urandom); dimY = 8'($urandom);
        matSel = 1'($urandom); fillState = 2'($urandom);
        while (q.size() > 0 && cyc < 600) begin
            case (readyMode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3) == 0;
                default: rdy = $urandom_range(0, 3) != 0;
            endcase
            outReady = rdy;
            check("valid",  32'(outValid),  1);
            check("busy",   32'(busy),      1);
            check("err",    32'(errPulse),  0);
            check("elem",   32'(outElem),   32'(q[0].elem));
            check("row",    32'(outRow),    32'(q[0].row));
            check("col",    32'(outCol),    32'(q[0].col));
            check("rowEnd", 32'(outRowEnd), 32'(q[0].rowEnd));
            check("last",   32'(outLast),   32'(q[0].last));
            tick();
            cyc++;
            if (rdy) begin
                void'(q.pop_front());
                hs++;
                if (hs == abortAfter) begin
                    outReady = 1'b0;
                    return;
                end
            end
        end
        check("stream_timeout", 32'(q.size()), 0);
        outReady = 1'b0;
        check("done_busy",  32'(busy),     0);
        check("done_valid", 32'(outValid), 0);
        check("done_last",  32'(outLast),  0);
    endtask

    task automatic reject(input int dx, input int dy, input bit sel, input logic [1:0] fill, input string tag);
        dimX = 8'(dx); dimY = 8'(dy); matSel = sel; fillState = fill;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_err"},   32'(errPulse), 1);
        check({tag, "_busy"},  32'(busy),     0);
        check({tag, "_valid"}, 32'(outValid), 0);
        tick();
        check({tag, "_errLow"}, 32'(errPulse), 0);
        check({tag, "_busy2"},  32'(busy),     0);
    endtask

    initial begin
        int  dx;
        int  dy;
        bit  sel;
        rst = 1'b1; start = 1'b0; matSel = 1'b0; dimX = 8'd0; dimY = 8'd0;
        readData = '0; fillState = FILL_EMPTY; outReady = 1'b0;
        tick(); tick();
        checkIdleOutputs("reset");
        rst = 1'b0;
        tick();
        checkIdleOutputs("postReset");

        // 2x3 stream of 1..6 from slot 0
        for (int e = 0; e < MAX_ELEM; e++) mat[e] = 8'(e + 1);
        runStream(3, 2, 1'b0, FILL_ONE, 0, 1'b0, 0);

        // 3x3 under 1,0,0 backpressure
        for (int e = 0; e < MAX_ELEM; e++) mat[e] = 8'($urandom);
        runStream(3, 3, 1'b0, FILL_TWO, 1, 1'b0, 0);

        reject(0, 3, 1'b0, FILL_ONE, "rejDimX0");
        reject(3, 6, 1'b0, FILL_ONE, "rejDimY6");
        reject(2, 2, 1'b1, FILL_ONE, "rejSlot1");
        reject(2, 2, 1'b0, FILL_EMPTY, "rejEmpty");

        // 5x5 from slot 1, values 100..124, bus overwritten after accept
        for (int e = 0; e < MAX_ELEM; e++) mat[e] = 8'(100 + e);
        runStream(5, 5, 1'b1, FILL_TWO, 0, 1'b0, 0);

        // Reset after the 4th handshake of a 4x4
        for (int e = 0; e < MAX_ELEM; e++) mat[e] = 8'($urandom);
        runStream(4, 4, 1'b0, FILL_ONE, 0, 1'b0, 4);
        rst = 1'b1;
        tick();
        checkIdleOutputs("midReset");
        rst = 1'b0;
        mat[0] = 8'hA5;
        runStream(1, 1, 1'b0, FILL_ONE, 0, 1'b0, 0);

        // start held through a stream: the next stream is accepted on the following edge
        for (int e = 0; e < MAX_ELEM; e++) mat[e] = 8'($urandom);
        runStream(2, 2, 1'b0, FILL_ONE, 2, 1'b1, 0);
        for (int e = 0; e < MAX_ELEM; e++) mat[e] = 8'($urandom);
        runStream(3, 1, 1'b0, FILL_ONE, 0, 1'b0, 0);

        // Randomized legal streams
        for (int n = 0; n < 8; n++) begin
            dx  = $urandom_range(1, MAX_DIM);
            dy  = $urandom_range(1, MAX_DIM);
            sel = 1'($urandom);
            for (int e = 0; e < MAX_ELEM; e++) mat[e] = 8'($urandom);
            runStream(dx, dy, sel, sel ? FILL_TWO : FILL_ONE, 2, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
